// File: rtl/clp_pkg.sv
// clp_pkg -- shared types, default timing and helpers for the PmodCLP
// character LCD write scheduler.
//   clp_state_t        : write FSM state encoding
//   CLP_T_AS..CLP_T_CLR: default HD44780 write timing in 50 MHz cycles
//   clp_is_long_cmd()  : true for clear/home commands that need the long wait
package clp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } clp_state_t;

  localparam int CLP_T_AS  = 3;      // 60 ns address setup
  localparam int CLP_T_PW  = 12;     // 240 ns E pulse width
  localparam int CLP_T_H   = 1;      // hold after E falls
  localparam int CLP_T_CMD = 2000;   // 40 us normal command execution
  localparam int CLP_T_CLR = 82000;  // 1.64 ms clear / return home

  // Clear display (0x01) and return home (0x02/0x03) are the only
  // instructions whose execution time is in the millisecond range.
  function automatic logic clp_is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/clp_rr_arbiter.sv
// clp_rr_arbiter -- two-way grant logic for the LCD write scheduler.
// Build option: define CLP_RR_ARB_EN for round-robin arbitration; by default
// port 0 has fixed priority and no last-grant state exists.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   valid[1:0]: request valids of port 1/port 0
//   accept   : a transfer takes place this cycle
//   idle     : scheduler can accept a request this cycle
//   grant[1:0]: one-hot grant, zero when not idle or nothing is valid
module clp_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  input  logic       idle,
  output logic [1:0] grant
);

`ifdef CLP_RR_ARB_EN
  // 1 = port 1 was granted most recently; reset favours port 0 first.
  logic last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (idle) begin
      if (&valid) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk, rst, accept};

  always_comb begin
    grant = 2'b00;
    if (idle) begin
      if (valid[0]) begin
        grant = 2'b01;
      end else if (valid[1]) begin
        grant = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/clp_write_sched.sv
// clp_write_sched -- arbitrated byte-write scheduler for the PmodCLP LCD.
// Takes RS+byte writes from two valid/ready requesters (port 0: init
// sequencer, port 1: text writer) and plays each one onto the HD44780 bus:
// address setup, E pulse, hold, then the command execution wait.
// Build option: CLP_RR_ARB_EN selects round-robin arbitration (see
// clp_rr_arbiter); default is fixed priority to port 0.
// Ports:
//   CLK, btnr                    : 50 MHz clock, async active-high reset
//   reqN_valid/rs/data, reqN_ready: write request handshakes (N = 0, 1)
//   lcd_db, lcd_rs, lcd_rw, lcd_e : registered LCD bus (rw tied low)
//   busy                          : a write is in progress
module clp_write_sched
  import clp_pkg::*;
#(
  parameter int T_AS  = CLP_T_AS,
  parameter int T_PW  = CLP_T_PW,
  parameter int T_H   = CLP_T_H,
  parameter int T_CMD = CLP_T_CMD,
  parameter int T_CLR = CLP_T_CLR
) (
  input  logic       CLK,
  input  logic       btnr,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy
);

  localparam int M1 = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int M2 = (M1 > T_H) ? M1 : T_H;
  localparam int M3 = (M2 > T_CMD) ? M2 : T_CMD;
  localparam int M4 = (M3 > T_CLR) ? M3 : T_CLR;
  localparam int CW = $clog2(M4) + 1;

  // Each phase counts down from length-1 to 0.
  localparam logic [CW-1:0] LD_AS  = CW'(T_AS - 1);
  localparam logic [CW-1:0] LD_PW  = CW'(T_PW - 1);
  localparam logic [CW-1:0] LD_H   = CW'(T_H - 1);
  localparam logic [CW-1:0] LD_CMD = CW'(T_CMD - 1);
  localparam logic [CW-1:0] LD_CLR = CW'(T_CLR - 1);

  clp_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cnt_zero;
  logic          idle;
  logic [1:0]    grant;
  logic          accept;
  logic          sel_rs;
  logic [7:0]    sel_data;

  assign cnt_zero = (cnt == '0);
  assign idle     = (state == ST_IDLE);
  assign accept   = req0_ready | req1_ready;
  assign sel_rs   = grant[1] ? req1_rs   : req0_rs;
  assign sel_data = grant[1] ? req1_data : req0_data;
  assign lcd_rw   = 1'b0;

  clp_rr_arbiter u_arb (
    .clk    (CLK),
    .rst    (btnr),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .idle   (idle),
    .grant  (grant)
  );

  always_ff @(posedge CLK or posedge btnr) begin
    if (btnr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)   state_nxt = ST_SETUP;
      ST_SETUP: if (cnt_zero) state_nxt = ST_PULSE;
      ST_PULSE: if (cnt_zero) state_nxt = ST_HOLD;
      ST_HOLD:  if (cnt_zero) state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt_zero) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant[0] & req0_valid;
    req1_ready = grant[1] & req1_valid;
    busy       = !idle;
  end

  // The wait length is chosen from the byte still sitting on the bus, so
  // no separate copy of the command is kept.
  always_comb begin
    cnt_nxt = cnt;
    case (state)
      ST_IDLE:  if (accept) cnt_nxt = LD_AS;
      ST_SETUP: cnt_nxt = cnt_zero ? LD_PW : cnt - CW'(1);
      ST_PULSE: cnt_nxt = cnt_zero ? LD_H  : cnt - CW'(1);
      ST_HOLD:  cnt_nxt = cnt_zero ? (clp_is_long_cmd(lcd_rs, lcd_db) ? LD_CLR : LD_CMD)
                                   : cnt - CW'(1);
      ST_WAIT:  cnt_nxt = cnt_zero ? '0 : cnt - CW'(1);
      default:  cnt_nxt = '0;
    endcase
  end

  // ---- bus register stage: E is high exactly while the FSM sits in PULSE
  always_ff @(posedge CLK or posedge btnr) begin
    if (btnr) begin
      cnt    <= '0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_db <= 8'h00;
    end else begin
      cnt   <= cnt_nxt;
      lcd_e <= (state_nxt == ST_PULSE);
      if (accept) begin
        lcd_rs <= sel_rs;
        lcd_db <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_clp_write_sched.sv
// tb_clp_write_sched -- self-checking bench for clp_write_sched with short
// timing (T_AS=2, T_PW=3, T_H=1, T_CMD=5, T_CLR=20). A cycle-level model
// predicts every output from the accept times; literal expectations pin
// latencies, pulse widths and arbitration order. Honours CLP_RR_ARB_EN.
module tb_clp_write_sched;

  localparam int T_AS  = 2;
  localparam int T_PW  = 3;
  localparam int T_H   = 1;
  localparam int T_CMD = 5;
  localparam int T_CLR = 20;

  logic       CLK;
  logic       btnr;
  logic       req0_valid, req0_rs, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_ready;
  logic [7:0] req1_data;
  logic [7:0] lcd_db;
  logic       lcd_rs, lcd_rw, lcd_e, busy;

  clp_write_sched #(
    .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .CLK        (CLK),
    .btnr       (btnr),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .lcd_db     (lcd_db),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_active = 1'b0;
  int         m_a = -1000;
  int         m_tw = 0;
  logic [7:0] m_db = 8'h00;
  logic       m_rs = 1'b0;
  bit         m_last = 1'b1;
  bit         prev_e = 1'b0;
  logic [7:0] prev_db = 8'h00;

  // accept log observed on the DUT handshake
  int acc_cyc[0:31];
  int acc_port[0:31];
  int n_acc = 0;

  logic       e_hist[0:4095];
  logic       busy_hist[0:4095];
  logic [7:0] db_hist[0:4095];
  logic       rs_hist[0:4095];

  function automatic bit long_cmd(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

  always @(negedge CLK) begin
    bit e_busy, e_e, e_r0, e_r1, idle;
    if (btnr) begin
      m_active = 1'b0;
      m_db     = 8'h00;
      m_rs     = 1'b0;
      m_last   = 1'b1;
    end
    e_busy = m_active && (cyc >= m_a + 1) && (cyc <= m_a + T_AS + T_PW + T_H + m_tw);
    e_e    = m_active && (cyc >= m_a + T_AS + 1) && (cyc <= m_a + T_AS + T_PW);
    idle   = !e_busy && !btnr;
    e_r0   = 1'b0;
    e_r1   = 1'b0;
    if (idle) begin
      if (req0_valid && req1_valid) begin
`ifdef CLP_RR_ARB_EN
        if (m_last) e_r0 = 1'b1; else e_r1 = 1'b1;
`else
        e_r0 = 1'b1;
`endif
      end else begin
        e_r0 = req0_valid;
        e_r1 = req1_valid;
      end
    end

    chk("lcd_e",  int'(lcd_e),  int'(e_e));
    chk("busy",   int'(busy),   int'(e_busy));
    chk("lcd_db", int'(lcd_db), int'(m_db));
    chk("lcd_rs", int'(lcd_rs), int'(m_rs));
    chk("lcd_rw", int'(lcd_rw), 0);
    chk("ready0", int'(req0_ready), int'(e_r0));
    chk("ready1", int'(req1_ready), int'(e_r1));
    if (prev_e && lcd_e) chk("db_stable_e", int'(lcd_db), int'(prev_db));
    prev_e  = btnr ? 1'b0 : lcd_e;
    prev_db = lcd_db;

    if (cyc < 4096) begin
      e_hist[cyc]    = lcd_e;
      busy_hist[cyc] = busy;
      db_hist[cyc]   = lcd_db;
      rs_hist[cyc]   = lcd_rs;
    end
    if (n_acc < 32) begin
      if (req0_valid && req0_ready) begin
        acc_cyc[n_acc] = cyc; acc_port[n_acc] = 0; n_acc = n_acc + 1;
      end else if (req1_valid && req1_ready) begin
        acc_cyc[n_acc] = cyc; acc_port[n_acc] = 1; n_acc = n_acc + 1;
      end
    end

    if (e_r0 || e_r1) begin
      m_active = 1'b1;
      m_a      = cyc;
      m_rs     = e_r0 ? req0_rs : req1_rs;
      m_db     = e_r0 ? req0_data : req1_data;
      m_tw     = long_cmd(m_rs, m_db) ? T_CLR : T_CMD;
      m_last   = e_r1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input int port, input logic rs, input logic [7:0] d);
    bit got;
    int k;
    @(posedge CLK); #1;
    if (port == 0) begin
      req0_rs = rs; req0_data = d; req0_valid = 1'b1;
    end else begin
      req1_rs = rs; req1_data = d; req1_valid = 1'b1;
    end
    got = 1'b0;
    k = 0;
    while (!got && k < 200) begin
      @(negedge CLK);
      got = (port == 0) ? req0_ready : req1_ready;
      k = k + 1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge CLK); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int k, cnt, ec, bc, first_e;
    btnr = 1'b1;
    req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
    repeat (3) @(posedge CLK);
    #1 btnr = 1'b0;
    @(negedge CLK);
    chk("reset_db",   int'(lcd_db), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_e",    int'(lcd_e), 0);

    // port 1 data write twice back to back: second request waits while busy
    do_write(1, 1'b1, 8'h41);
    do_write(1, 1'b1, 8'h42);
    // port 0 clear, then normal command twice, then port 1 so port 0 is next
    do_write(0, 1'b0, 8'h01);
    do_write(0, 1'b0, 8'h38);
    do_write(0, 1'b0, 8'h38);
    do_write(1, 1'b1, 8'h20);

    // contention: both valid until four accepts
    @(posedge CLK); #1;
    req0_rs = 1'b1; req0_data = 8'hA0; req0_valid = 1'b1;
    req1_rs = 1'b1; req1_data = 8'hB1; req1_valid = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 4 && k < 400) begin
      @(negedge CLK);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) cnt = cnt + 1;
      k = k + 1;
    end
    if (cnt < 4) chk("contention_timeout", cnt, 4);
    @(posedge CLK); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // reset during PULSE
    do_write(1, 1'b1, 8'h55);
    k = 0;
    while (!lcd_e && k < 50) begin
      @(negedge CLK);
      k = k + 1;
    end
    chk("saw_pulse", int'(lcd_e), 1);
    @(posedge CLK); #1;
    btnr = 1'b1;
    #1;
    chk("rst_async_e",    int'(lcd_e), 0);
    chk("rst_async_db",   int'(lcd_db), 0);
    chk("rst_async_busy", int'(busy), 0);
    @(posedge CLK); #1;
    btnr = 1'b0;
    do_write(0, 1'b1, 8'h5A);
    repeat (20) @(posedge CLK);

    // ---------------- literal expectations ----------------
    chk("accept_count", n_acc, 12);
    if (n_acc >= 12) begin
      chk("a2a_data", acc_cyc[1] - acc_cyc[0], 12);
      chk("db_after_accept", int'(db_hist[acc_cyc[0] + 1]), 8'h41);
      chk("rs_after_accept", int'(rs_hist[acc_cyc[0] + 1]), 1);
      ec = 0; bc = 0; first_e = -1;
      for (int c = acc_cyc[0]; c < acc_cyc[1]; c++) begin
        if (e_hist[c]) begin
          ec = ec + 1;
          if (first_e < 0) first_e = c;
        end
        if (busy_hist[c]) bc = bc + 1;
      end
      chk("e_high_cycles", ec, 3);
      chk("e_rise_offset", first_e - acc_cyc[0], 3);
      chk("busy_cycles", bc, 11);
      chk("a2a_clear", acc_cyc[3] - acc_cyc[2], 27);
      chk("a2a_cmd38", acc_cyc[4] - acc_cyc[3], 12);
      chk("port_clear", acc_port[2], 0);
`ifdef CLP_RR_ARB_EN
      chk("arb_g0", acc_port[6], 0);
      chk("arb_g1", acc_port[7], 1);
      chk("arb_g2", acc_port[8], 0);
      chk("arb_g3", acc_port[9], 1);
`else
      chk("arb_g0", acc_port[6], 0);
      chk("arb_g1", acc_port[7], 0);
      chk("arb_g2", acc_port[8], 0);
      chk("arb_g3", acc_port[9], 0);
`endif
      chk("post_rst_port", acc_port[11], 0);
      chk("post_rst_db", int'(db_hist[acc_cyc[11] + 1]), 8'h5A);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

endmodule
